// File: rtl/pad_serial_reader.sv
// pad_serial_reader: SFC controller port master that polls both pads and publishes decoded buttons.
module pad_serial_reader #(
  parameter int HALF_CYCLES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic [1:0]  connect,
  output logic        busy,
  output logic        done
);
  localparam int PW = $clog2(2 * HALF_CYCLES);
  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0] bit_q, bit_d;
  logic [1:0] sync1_q, sync2_q;
  logic [15:0] raw1_q, raw1_d, raw2_q, raw2_d;
  logic [11:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic [1:0] conn_q, conn_d;
  logic [16:0] new1, new2;
  logic [11:0] dec1, dec2;
  logic last_latch, last_half;
  // new* is the stored history plus the bit being sampled this cycle; after the final sample it holds raw bits 16..0
  assign new1 = {sync2_q[0], raw1_q};
  assign new2 = {sync2_q[1], raw2_q};
  assign last_latch = phase_q == PW'(2 * HALF_CYCLES - 1);
  assign last_half = phase_q == PW'(HALF_CYCLES - 1);
  always_comb begin
    dec1 = '0;
    dec2 = '0;
    for (int i = 0; i < 12; i++) begin
      dec1[11-i] = ~new1[i];
      dec2[11-i] = ~new2[i];
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    bit_d = bit_q;
    raw1_d = raw1_q;
    raw2_d = raw2_q;
    joy1_d = joy1_q;
    joy2_d = joy2_q;
    conn_d = conn_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d = LATCH;
          bit_d = '0;
        end
      end
      LATCH: if (last_latch) begin
        state_d = CLK_LO;
        phase_d = '0;
        raw1_d = new1[16:1];
        raw2_d = new2[16:1];
      end
      CLK_LO: if (last_half) begin
        state_d = CLK_HI;
        phase_d = '0;
      end
      CLK_HI: if (last_half) begin
        phase_d = '0;
        bit_d = bit_q + 1'b1;
        raw1_d = new1[16:1];
        raw2_d = new2[16:1];
        state_d = (bit_q == 5'd15) ? DONE : CLK_LO;
        if (bit_q == 5'd15) begin
          joy1_d = dec1;
          joy2_d = dec2;
          conn_d = {~new2[16] & (&new2[15:12]), ~new1[16] & (&new1[15:12])};
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
      raw1_q <= '0;
      raw2_q <= '0;
      joy1_q <= '0;
      joy2_q <= '0;
      conn_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q <= bit_d;
      sync1_q <= pad_data;
      sync2_q <= sync1_q;
      raw1_q <= raw1_d;
      raw2_q <= raw2_d;
      joy1_q <= joy1_d;
      joy2_q <= joy2_d;
      conn_q <= conn_d;
    end
  end
  assign pad_latch = state_q == LATCH;
  assign pad_clk = state_q != CLK_LO;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign joy1 = joy1_q;
  assign joy2 = joy2_q;
  assign connect = conn_q;
endmodule

// File: tb/tb_pad_serial_reader.sv
// tb_pad_serial_reader: pad models on both ports, scoreboard of expected poll results.
module tb_pad_serial_reader;
  localparam int H = 4;
  logic clk = 0, reset = 0, start = 0;
  logic [1:0] pad_data;
  logic pad_latch, pad_clk, busy, done;
  logic [11:0] joy1, joy2;
  logic [1:0] connect;
  int cyc = 0, checks = 0, fails = 0;
  logic [11:0] btn1 = 0, btn2 = 0;
  logic unplug2 = 0;
  logic [15:0] sr1 = '1, sr2 = '1;
  logic pclk_prev = 1;
  logic [25:0] exp_q[$];
  int t0, lat_first, lat_last, lat_n, pulses, bad_len, done_n, done_at, busy_last;
  logic [25:0] got;

  pad_serial_reader #(.HALF_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .start(start), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .joy1(joy1), .joy2(joy2),
    .connect(connect), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial word of a standard pad: bit 0 = B ... bit 11 = R, active-low, ID bits 12..15 high
  function automatic logic [15:0] ser(input logic [11:0] b);
    logic [15:0] w;
    w = 16'hFFFF;
    for (int i = 0; i < 12; i++) w[i] = ~b[11-i];
    return w;
  endfunction

  always @(posedge clk) begin
    pclk_prev <= pad_clk;
    if (pad_latch) begin
      sr1 <= ser(btn1);
      sr2 <= ser(btn2);
    end else if (pad_clk && !pclk_prev) begin
      sr1 <= {1'b0, sr1[15:1]};
      sr2 <= {1'b0, sr2[15:1]};
    end
  end
  assign pad_data = {unplug2 ? 1'b1 : sr2[0], sr1[0]};

  function automatic logic [25:0] expect_res(input logic [11:0] b1, b2, input logic u2);
    return {b1, u2 ? 12'h000 : b2, ~u2, 1'b1};
  endfunction

  task automatic start_poll();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic run_poll(input logic [11:0] b1, b2, input logic u2);
    bit ok;
    logic [25:0] e;
    btn1 = b1;
    btn2 = b2;
    unplug2 = u2;
    exp_q.push_back(expect_res(b1, b2, u2));
    start_poll();
    ok = 0;
    for (int k = 0; k < 40 * H + 20 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", 40 * H + 20);
    end else begin
      checks++;
      if ({joy1, joy2, connect} !== e) begin
        fails++;
        $display("FAIL poll_result: got joy1=%h joy2=%h connect=%b, expected joy1=%h joy2=%h connect=%b",
                 joy1, joy2, connect, e[25:14], e[13:2], e[1:0]);
      end
    end
  endtask

  task automatic run_measured(input int restart_at);
    int c, lo_run;
    lat_first = -1; lat_last = -1; lat_n = 0; pulses = 0; bad_len = 0;
    done_n = 0; done_at = -1; busy_last = -1; lo_run = 0; got = 'x;
    @(posedge clk);
    #1 start = 1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 0;
    for (int k = 0; k < 40 * H; k++) begin
      @(negedge clk);
      c = cyc - t0;
      if (pad_latch) begin
        if (lat_first < 0) lat_first = c;
        lat_last = c;
        lat_n++;
      end
      if (!pad_clk) lo_run++;
      else if (lo_run > 0) begin
        pulses++;
        if (lo_run != H) bad_len++;
        lo_run = 0;
      end
      if (done) begin
        done_n++;
        done_at = c;
        got = {joy1, joy2, connect};
      end
      if (busy) busy_last = c;
      start = (c == restart_at);
    end
    start = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pad_latch, pad_clk, busy, done} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_ctrl: got latch/clk/busy/done=%b, expected 0100", {pad_latch, pad_clk, busy, done});
    end
    checks++;
    if ({joy1, joy2, connect} !== 26'd0) begin
      fails++;
      $display("FAIL reset_data: got joy1=%h joy2=%h connect=%b, expected all 0", joy1, joy2, connect);
    end
    reset = 1;
  endtask

  task automatic test_basic();
    run_poll(12'h801, 12'h000, 0);
  endtask

  task automatic test_unplugged();
    run_poll(12'hFFF, 12'h000, 1);
    unplug2 = 0;
  endtask

  task automatic check_measured(input string name);
    logic [25:0] e;
    e = exp_q.pop_front();
    checks++;
    if (lat_first != 1 || lat_last != 2 * H || lat_n != 2 * H) begin
      fails++;
      $display("FAIL %s latch_window: got first=%0d last=%0d n=%0d, expected 1 %0d %0d", name, lat_first, lat_last, lat_n, 2 * H, 2 * H);
    end
    checks++;
    if (pulses != 16 || bad_len != 0) begin
      fails++;
      $display("FAIL %s clk_pulses: got %0d pulses (%0d wrong length), expected 16 of %0d cycles", name, pulses, bad_len, H);
    end
    checks++;
    if (done_n != 1 || done_at != 1 + 34 * H) begin
      fails++;
      $display("FAIL %s done_timing: got %0d pulses last at +%0d, expected 1 at +%0d", name, done_n, done_at, 1 + 34 * H);
    end
    checks++;
    if (busy_last != 34 * H + 1) begin
      fails++;
      $display("FAIL %s busy_end: got last busy at +%0d, expected +%0d", name, busy_last, 34 * H + 1);
    end
    checks++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s poll_result: got %h, expected %h", name, got, e);
    end
  endtask

  task automatic test_cycle_count();
    btn1 = 12'h801; btn2 = 12'h400; unplug2 = 0;
    exp_q.push_back(expect_res(btn1, btn2, 0));
    run_measured(0);
    check_measured("cycle_count");
  endtask

  task automatic test_restart_ignored();
    btn1 = 12'h0F0; btn2 = 12'h00F; unplug2 = 0;
    exp_q.push_back(expect_res(btn1, btn2, 0));
    run_measured(50);
    check_measured("restart_ignored");
  endtask

  task automatic test_reset_mid_poll();
    int falls;
    logic prev;
    btn1 = 12'h123; btn2 = 12'h456;
    start_poll();
    falls = 0;
    prev = 1;
    for (int k = 0; k < 40 * H && falls < 8; k++) begin
      @(negedge clk);
      if (prev && !pad_clk) falls++;
      prev = pad_clk;
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if ({pad_latch, pad_clk, busy, done} !== 4'b0100 || joy1 !== 12'h000 || connect !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_poll: got latch/clk/busy/done=%b joy1=%h connect=%b, expected 0100 000 00",
               {pad_latch, pad_clk, busy, done}, joy1, connect);
    end
    reset = 1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || joy1 !== 12'h000) begin
      fails++;
      $display("FAIL reset_no_resume: got busy=%b joy1=%h, expected 0 000", busy, joy1);
    end
    run_poll(12'h801, 12'h000, 0);
  endtask

  task automatic test_button_change();
    int bad;
    run_poll(12'h080, 12'h000, 0);
    btn1 = 12'h000;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (joy1 !== 12'h080 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_between_polls: got %0d unstable cycles, expected 0 (joy1 held at 080)", bad);
    end
    run_poll(12'h000, 12'h000, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unplugged();
    test_cycle_count();
    test_restart_ignored();
    test_reset_mid_poll();
    test_button_change();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pad_serial_reader.md
# pad_serial_reader

Console-side master for the two physical SFC controller ports: on request it drives the serial latch/clock protocol, shifts in 17 bits per port from the pad data lines, and publishes decoded 12-bit button vectors plus per-port connect flags. Its `joy1`/`joy2`/`connect` outputs feed the joypad register block, which consumes exactly this format (bit 11 = B … bit 0 = R, active-high pressed). Triggering is typically tied to the vblank auto-read strobe.

## Interface
- `HALF_CYCLES`, default 128: clk cycles per half pad-clock period (~6 µs at 21.477 MHz); legal range ≥ 4.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low (0 = reset).
- `start` in 1: one-cycle poll request; ignored while `busy`.
- `pad_data` in 2: raw serial data, [0] = port 1, [1] = port 2; asynchronous, active-low (0 = pressed), pulled high when unplugged.
- `pad_latch` out 1: latch strobe to both ports, active-high.
- `pad_clk` out 1: shift clock to both ports, idles high; pads shift on rising edge.
- `joy1` out 12: port-1 buttons, active-high; [11..0] = B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
- `joy2` out 12: port-2 buttons, same order.
- `connect` out 2: [n] = 1 when port n+1 answered as a standard pad on the last poll.
- `busy` out 1: high from the cycle after accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse when new results are visible.

## Operation
- `pad_data` passes through a 2-flop synchronizer per bit before any use.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
- IDLE: `pad_latch`=0, `pad_clk`=1. `start`=1 → LATCH, phase counter cleared, bit counter = 0.
- LATCH: `pad_latch`=1 for 2×HALF_CYCLES cycles. On the last cycle, sample synchronized data as raw bit 0; go to CLK_LO, `pad_latch`=0.
- CLK_LO: `pad_clk`=0 for HALF_CYCLES cycles → CLK_HI.
- CLK_HI: `pad_clk`=1 for HALF_CYCLES cycles. On the last cycle, increment the bit counter and sample raw bit[counter]. After raw bit 16 is sampled → DONE, else → CLK_LO.
- Shift storage: 17 raw bits per port (bits 0..16).
- DONE (1 cycle): update `joyN[11-i]` = ~raw[i] for i = 0..11; `connect[n]` = (raw bit 16 == 0) AND (raw bits 12..15 all 1); `done`=1; → IDLE.
- A disconnected port (floating high) yields `joy`=0 and `connect`=0 through the same formula; no special-casing.
- `joy*`/`connect` are held between polls and change only in DONE, atomically for both ports.
- `start` in IDLE and DONE cycles: DONE ignores it; the caller re-requests.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=1, `joy1`=`joy2`=0, `connect`=0, `busy`=0, `done`=0, FSM=IDLE, synchronizers cleared to 1.
- Reset mid-poll aborts immediately; outputs return to reset values on the next edge; no partial result is published.
- `start` at cycle T → `pad_latch` rises at T+1; latch high for 2H cycles (H = HALF_CYCLES).
- 16 clock pulses each 2H cycles (H low, H high); total active length 34H cycles; `done` at cycle T+1+34H; `busy` high T+1 … T+34H+1 inclusive.
- Sample point = last cycle of each phase, ≥ H−1 cycles after the relevant edge, which covers 2-cycle synchronizer latency for H ≥ 4.
- Counters: phase counter ⌈log2(2H)⌉ bits, bit counter 5 bits (0..16); no wrap beyond 16.

## Test plan
- Pad model per port (latched 16-bit word, shifts on `pad_clk` rise, outputs 0 after 16 bits), H=4: port 1 presses B and R only, port 2 none → after `done`, `joy1`=12'h801, `joy2`=12'h000, `connect`=2'b11.
- Port 2 unplugged (`pad_data[1]` tied 1), port 1 all buttons pressed → `joy1`=12'hFFF, `joy2`=0, `connect`=2'b01.
- Cycle count, H=4: `start` at cycle 10 → `pad_latch` high cycles 11–18, exactly 16 `pad_clk` low pulses of 4 cycles each, `done` at cycle 147, `busy` low at 148.
- `start` pulsed again mid-poll → ignored: still 16 clock pulses, a single `done`.
- `reset`=0 during bit 7 → next cycle `pad_latch`=0, `pad_clk`=1, `busy`=0, `joy1`/`connect`=0; a fresh poll then returns correct values.
- Button change between two polls (Up pressed, then released) → `joy1`=12'h080 after poll 1, 12'h000 after poll 2; outputs stable between the `done` pulses.
